// File: rtl/rasterint_pkg.sv
// Shared definitions for the raster interrupt sequencer: FSM state encoding,
// pulse counter width and default beam timing per machine model.
package rasterint_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PULSE_VRT = 2'd1,
    PULSE_RAS = 2'd2
  } state_e;

  localparam int BEAM_W = 9;
  localparam int CNT_W  = 8;

  // Retrace line and lines-per-frame for the supported timing modes.
  localparam int VRT_LINE_48K  = 248;
  localparam int LINES_48K     = 312;
  localparam int VRT_LINE_128K = 247;
  localparam int LINES_128K    = 311;
  localparam int VRT_LINE_PENT = 239;
  localparam int LINES_PENT    = 320;

endpackage : rasterint_pkg

// File: rtl/rasterint_trigger.sv
// Beam-position comparator: registers a line/column match and emits a
// single-cycle trigger on its rising edge, so a held match fires once.
module rasterint_trigger
  import rasterint_pkg::*;
#(
  parameter int TRIG_HC = 0,
  parameter int LINES   = 312
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BEAM_W-1:0] hc,
  input  logic [BEAM_W-1:0] vc,
  input  logic [BEAM_W-1:0] line,
  output logic              trig
);

  logic match;
  logic match_q;
  logic prev_q;

  // A line number at or beyond the frame length can never be reached.
  assign match = (vc == line) &&
                 (hc == BEAM_W'(TRIG_HC)) &&
                 ({1'b0, line} < (BEAM_W + 1)'(LINES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      match_q <= match;
      prev_q  <= match_q;
    end
  end

  assign trig = match_q & ~prev_q;

endmodule : rasterint_trigger

// File: rtl/rasterint_sequencer.sv
// Z80 /INT pulse generator choosing between retrace and raster-line interrupts.
// Optional build macro RASTERINT_ACK_EN ends the pulse early on an M1+IORQ acknowledge.
module rasterint_sequencer
  import rasterint_pkg::*;
#(
  parameter int INT_LEN  = 32,
  parameter int VRT_LINE = 248,
  parameter int TRIG_HC  = 0,
  parameter int LINES    = 312
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_clken,
  input  logic [BEAM_W-1:0] hc,
  input  logic [BEAM_W-1:0] vc,
  input  logic              rasterint_enable,
  input  logic              vretraceint_disable,
  input  logic [BEAM_W-1:0] raster_line,
  input  logic              m1_n,
  input  logic              iorq_n,
  output logic              int_n,
  output logic              raster_int_in_progress,
  output state_e            state_dbg
);

  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(INT_LEN - 1);

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             int_n_nx;
  logic             rip_nx;
  logic             vrt_trig, ras_trig;
  logic             vrt_go, ras_go;
  logic             ack;

  rasterint_trigger #(.TRIG_HC(TRIG_HC), .LINES(LINES)) u_vrt_trig (
    .clk   (clk),
    .rst_n (rst_n),
    .hc    (hc),
    .vc    (vc),
    .line  (BEAM_W'(VRT_LINE)),
    .trig  (vrt_trig)
  );

  rasterint_trigger #(.TRIG_HC(TRIG_HC), .LINES(LINES)) u_ras_trig (
    .clk   (clk),
    .rst_n (rst_n),
    .hc    (hc),
    .vc    (vc),
    .line  (raster_line),
    .trig  (ras_trig)
  );

  assign vrt_go = vrt_trig & ~vretraceint_disable;
  assign ras_go = ras_trig & rasterint_enable;

`ifdef RASTERINT_ACK_EN
  assign ack = ~m1_n & ~iorq_n;
`else
  assign ack = 1'b0;
  logic unused_ack;
  assign unused_ack = m1_n ^ iorq_n;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                  <= IDLE;
      cnt                    <= '0;
      int_n                  <= 1'b1;
      raster_int_in_progress <= 1'b0;
    end else begin
      state                  <= state_nx;
      cnt                    <= cnt_nx;
      int_n                  <= int_n_nx;
      raster_int_in_progress <= rip_nx;
    end
  end

  // Triggers arriving outside IDLE are simply not looked at, so they drop.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    int_n_nx = int_n;
    rip_nx   = raster_int_in_progress;
    unique case (state)
      IDLE: begin
        if (ras_go) begin
          state_nx = PULSE_RAS;
          cnt_nx   = '0;
          int_n_nx = 1'b0;
          rip_nx   = 1'b1;
        end else if (vrt_go) begin
          state_nx = PULSE_VRT;
          cnt_nx   = '0;
          int_n_nx = 1'b0;
        end
      end
      PULSE_VRT, PULSE_RAS: begin
        if (ack || (cpu_clken && cnt == LAST_TICK)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          int_n_nx = 1'b1;
          rip_nx   = 1'b0;
        end else if (cpu_clken) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        int_n_nx = 1'b1;
        rip_nx   = 1'b0;
      end
    endcase
  end

  assign state_dbg = state;

endmodule : rasterint_sequencer

// File: tb/tb_rasterint_sequencer.sv
// Directed bench for rasterint_sequencer: beam positions are placed directly,
// pulse widths are measured in cpu_clken ticks against hand-computed values.
module tb_rasterint_sequencer;
  import rasterint_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_clken = 1'b0;
  logic [8:0] hc, vc, raster_line;
  logic       rasterint_enable, vretraceint_disable;
  logic       m1_n, iorq_n;
  logic       int_n, raster_int_in_progress;
  state_e     state_dbg;

  logic       clken_run = 1'b1;
  int         n_checks = 0;
  int         n_fail = 0;

`ifdef RASTERINT_ACK_EN
  localparam int ACK_TICKS = 5;
`else
  localparam int ACK_TICKS = 32;
`endif

  rasterint_sequencer dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .cpu_clken              (cpu_clken),
    .hc                     (hc),
    .vc                     (vc),
    .rasterint_enable       (rasterint_enable),
    .vretraceint_disable    (vretraceint_disable),
    .raster_line            (raster_line),
    .m1_n                   (m1_n),
    .iorq_n                 (iorq_n),
    .int_n                  (int_n),
    .raster_int_in_progress (raster_int_in_progress),
    .state_dbg              (state_dbg)
  );

  // clock / reset / clock-enable
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cpu_clken = clken_run ? ~cpu_clken : 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge
  task automatic hit_line(input logic [8:0] v);
    @(negedge clk);
    vc = v;
    hc = 9'd0;
  endtask

  task automatic leave_line();
    @(negedge clk);
    hc = 9'd5;
  endtask

  task automatic wait_low(input string tag, input int bound);
    bit got = 0;
    for (int i = 0; i < bound; i++) begin
      if (int_n === 1'b0) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq(tag, 32'(got), 32'd1);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    bit low_seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (int_n !== 1'b1) low_seen = 1;
    end
    check_eq(tag, 32'(low_seen), 32'd0);
  endtask

  // Counts cpu_clken ticks while int_n is low; optional ack or clken stall.
  task automatic measure(input string tag, input logic exp_rip, input int exp_ticks,
                         input int ack_at, input int hold_at, input bit drop_vrt_en);
    int ticks = 0;
    int n = 0;
    bit rip_bad = 0;
    bit held = 0;
    bit hold_ok = 1;
    while (int_n === 1'b0 && n < 2000) begin
      if (raster_int_in_progress !== exp_rip) rip_bad = 1;
      if (cpu_clken) ticks++;
      if (drop_vrt_en && ticks == 3) vretraceint_disable = 1'b1;
      if (ack_at != 0 && ticks == ack_at) begin
        m1_n   = 1'b0;
        iorq_n = 1'b0;
      end
      if (hold_at != 0 && ticks == hold_at && !held) begin
        held = 1;
        clken_run = 1'b0;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (int_n !== 1'b0) hold_ok = 0;
        end
        clken_run = 1'b1;
      end else begin
        @(negedge clk);
      end
      n++;
    end
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    vretraceint_disable = 1'b0;
    check_eq({tag, "_ticks"}, 32'(ticks), 32'(exp_ticks));
    check_eq({tag, "_rip_during"}, 32'(rip_bad), 32'd0);
    check_eq({tag, "_int_end"}, 32'(int_n), 32'd1);
    check_eq({tag, "_rip_end"}, 32'(raster_int_in_progress), 32'd0);
    if (hold_at != 0) check_eq({tag, "_hold"}, 32'(hold_ok), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    vc = 9'd0;
    hc = 9'd5;
    raster_line = 9'd0;
    rasterint_enable = 1'b0;
    vretraceint_disable = 1'b0;
    m1_n = 1'b1;
    iorq_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("rst_int_n", 32'(int_n), 32'd1);
    check_eq("rst_rip", 32'(raster_int_in_progress), 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'(IDLE));
    rst_n = 1'b1;

    // 1: retrace only, latency of two clocks
    hit_line(9'd248);
    @(negedge clk);
    check_eq("t1_lat1", 32'(int_n), 32'd1);
    @(negedge clk);
    check_eq("t1_lat2", 32'(int_n), 32'd0);
    check_eq("t1_state", 32'(state_dbg), 32'(PULSE_VRT));
    measure("t1", 1'b0, 32, 0, 0, 1'b0);
    expect_quiet("t1_no_refire", 20);
    leave_line();

    // 2: raster line 100, with a mid-pulse clken stall
    rasterint_enable = 1'b1;
    raster_line = 9'd100;
    hit_line(9'd100);
    wait_low("t2_fire", 6);
    check_eq("t2_state", 32'(state_dbg), 32'(PULSE_RAS));
    measure("t2", 1'b1, 32, 0, 8, 1'b0);
    leave_line();
    hit_line(9'd248);
    wait_low("t2_vrt_fire", 6);
    measure("t2v", 1'b0, 32, 0, 0, 1'b0);
    leave_line();

    // 3: both on the same line, raster wins and retrace is dropped
    raster_line = 9'd248;
    hit_line(9'd248);
    wait_low("t3_fire", 6);
    check_eq("t3_state", 32'(state_dbg), 32'(PULSE_RAS));
    measure("t3", 1'b1, 32, 0, 0, 1'b0);
    expect_quiet("t3_no_second", 50);
    leave_line();

    // 4: unreachable raster line never fires; retrace still does
    raster_line = 9'h1FF;
    for (int f = 0; f < 3; f++) begin
      hit_line(9'd100);
      expect_quiet($sformatf("t4_f%0d_l100", f), 10);
      leave_line();
      hit_line(9'h1FF);
      expect_quiet($sformatf("t4_f%0d_l511", f), 10);
      leave_line();
      hit_line(9'd248);
      wait_low($sformatf("t4_f%0d_vrt", f), 6);
      measure($sformatf("t4_f%0d", f), 1'b0, 32, 0, 0, 1'b0);
      leave_line();
    end

    // 5: reset in the middle of a raster pulse
    raster_line = 9'd100;
    hit_line(9'd100);
    wait_low("t5_fire", 6);
    begin
      int ticks = 0;
      for (int i = 0; i < 200 && ticks < 10; i++) begin
        if (cpu_clken) ticks++;
        if (ticks < 10) @(negedge clk);
      end
      check_eq("t5_ticks_before_rst", 32'(ticks), 32'd10);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t5_int_n", 32'(int_n), 32'd1);
    check_eq("t5_rip", 32'(raster_int_in_progress), 32'd0);
    check_eq("t5_state", 32'(state_dbg), 32'(IDLE));
    hc = 9'd5;
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet("t5_no_resume", 50);

    // 6: acknowledge at tick 5
    rasterint_enable = 1'b0;
    hit_line(9'd248);
    wait_low("t6_fire", 6);
    measure("t6", 1'b0, ACK_TICKS, 5, 0, 1'b0);
    leave_line();

    // 7: retrace disabled suppresses; disabling mid-pulse does not shorten
    vretraceint_disable = 1'b1;
    hit_line(9'd248);
    expect_quiet("t7_disabled", 10);
    leave_line();
    vretraceint_disable = 1'b0;
    hit_line(9'd248);
    wait_low("t7_fire", 6);
    measure("t7", 1'b0, 32, 0, 0, 1'b1);
    leave_line();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rasterint_sequencer
